// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: FSM states, request op encoding and word width.
package dm_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } op_e;

  // Both strobes together is illegal; it still runs the full latency and reports an error.
  function automatic op_e classify_op(input logic rd, input logic wr);
    if (rd && wr)
      return OP_BAD;
    else if (wr)
      return OP_WR;
    else
      return OP_RD;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// CPU data-memory port: request strobes and address/data from the CPU, stall/ack/err/rdata back.
interface dm_responder_if;
  import dm_pkg::*;

  logic              rd_i;
  logic              wr_i;
  logic [31:0]       addr_i;
  logic [WORD_W-1:0] wdata_i;
  logic [WORD_W-1:0] rdata_o;
  logic              stall_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output rd_i, wr_i, addr_i, wdata_i,
    input  rdata_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  rd_i, wr_i, addr_i, wdata_i,
    output rdata_o, stall_o, ack_o, err_o
  );
endinterface

// File: rtl/dm_array.sv
// Single-port synchronous word RAM; the read port is registered and holds between reads.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_responder.sv
// Slow data-memory target: services one CPU read/write at a time with a fixed latency,
// stalling the CPU until a one-cycle ack (with optional error) in the RESP state.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dm_responder_if.slave bus
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;

  op_e               op_p0;
  logic [AW-1:0]     word_p0;
  logic [WORD_W-1:0] wdata_p0;
  logic              err_p0;

  logic              req;
  logic              commit;
  logic              ram_we;
  logic              ram_re;
  logic              rdata_vld;
  logic [WORD_W-1:0] ram_rdata;

  logic              stall;
  logic              ack;
  logic              err;

  // Upper address bits only alias the array; they are intentionally dropped.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^bus.addr_i[31:AW+2];

  assign req    = bus.rd_i | bus.wr_i;
  assign commit = (state == BUSY) && (cnt == '0);
  assign ram_we = commit && !err_p0 && (op_p0 == OP_WR);
  assign ram_re = commit && !err_p0 && (op_p0 == OP_RD);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req)
          state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0)
          state_nxt = RESP;
      end
      // Inputs still show the serviced request here; returning to IDLE avoids re-servicing it.
      RESP: begin
        ack       = 1'b1;
        err       = err_p0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and latency counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt      <= '0;
      op_p0    <= OP_RD;
      word_p0  <= '0;
      wdata_p0 <= '0;
      err_p0   <= 1'b0;
    end else if ((state == IDLE) && req) begin
      cnt      <= CNT_W'(LATENCY - 1);
      op_p0    <= classify_op(bus.rd_i, bus.wr_i);
      word_p0  <= bus.addr_i[AW+1:2];
      wdata_p0 <= bus.wdata_i;
      err_p0   <= (classify_op(bus.rd_i, bus.wr_i) == OP_BAD) || (bus.addr_i[1:0] != 2'b00);
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // RAM output is only meaningful once a read has committed since reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      rdata_vld <= 1'b0;
    else if (ram_re)
      rdata_vld <= 1'b1;
  end

  dm_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_p0),
    .wdata (wdata_p0),
    .rdata (ram_rdata)
  );

  assign bus.rdata_o = rdata_vld ? ram_rdata : '0;
  assign bus.stall_o = stall;
  assign bus.ack_o   = ack;
  assign bus.err_o   = err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance at LATENCY=3 and one at LATENCY=1.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  bit          sel;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_responder_if ifa ();
  dm_responder_if ifb ();

  assign ifa.rd_i    = !sel & rd;
  assign ifa.wr_i    = !sel & wr;
  assign ifa.addr_i  = addr;
  assign ifa.wdata_i = wdata;
  assign ifb.rd_i    = sel & rd;
  assign ifb.wr_i    = sel & wr;
  assign ifb.addr_i  = addr;
  assign ifb.wdata_i = wdata;

  dm_responder #(.DEPTH(256), .LATENCY(3)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa.slave));
  dm_responder #(.DEPTH(256), .LATENCY(1)) dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb.slave));

  wire        stall = sel ? ifb.stall_o : ifa.stall_o;
  wire        ack   = sel ? ifb.ack_o   : ifa.ack_o;
  wire        err   = sel ? ifb.err_o   : ifa.err_o;
  wire [31:0] rdata = sel ? ifb.rdata_o : ifa.rdata_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves just after a rising edge.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rdata,
                        input int lat, input bit hold);
    rd = r; wr = w; addr = a; wdata = d;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check({tag, "_stall"}, 32'(stall), 32'd1);
      check({tag, "_noack"}, 32'(ack), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_rdata"}, rdata, e_rdata);
    if (!hold) begin
      rd = 1'b0; wr = 1'b0;
    end
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      check({tag, "_idle_stall"}, 32'(stall), 32'd1);
      check({tag, "_idle_ack"}, 32'(ack), 32'd0);
      rd = 1'b0; wr = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_no_reservice"}, 32'(stall), 32'd0);
      check({tag, "_no_reack"}, 32'(ack), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ifa.ack_o), 32'd0);
    check("rst_err", 32'(ifa.err_o), 32'd0);
    check("rst_rdata", ifa.rdata_o, 32'd0);
    check("rst_stall", 32'(ifa.stall_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 3, 1'b0);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b0);
    access("wr400", 1'b0, 1'b1, 32'h400, 32'h1234, 1'b0, 32'hDEADBEEF, 3, 1'b0);
    access("rd0_wrap", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1234, 3, 1'b0);
    access("misalign", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h1234, 3, 1'b0);
    access("wr20", 1'b0, 1'b1, 32'h20, 32'h55, 1'b0, 32'h1234, 3, 1'b0);
    access("illegal", 1'b1, 1'b1, 32'h20, 32'h99, 1'b1, 32'h1234, 3, 1'b0);
    access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55, 3, 1'b0);
    access("wr30_pre", 1'b0, 1'b1, 32'h30, 32'h1111, 1'b0, 32'h55, 3, 1'b0);

    // Write aborted by reset two cycles into the access
    rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ack", 32'(ifa.ack_o), 32'd0);
    check("abort_err", 32'(ifa.err_o), 32'd0);
    check("abort_rdata", ifa.rdata_o, 32'd0);
    wr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access("rd30_after_abort", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h1111, 3, 1'b0);

    access("hold_rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b1);

    sel = 1'b1;
    access("l1_wr8", 1'b0, 1'b1, 32'h8, 32'h77, 1'b0, 32'h0, 1, 1'b0);
    access("l1_rd8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h77, 1, 1'b1);
    access("l1_misalign", 1'b1, 1'b0, 32'h9, 32'h0, 1'b1, 32'h77, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
